vga_scanout: RTL and testbench

Display-side reader of the framebuffer. It generates 640x480@60 Hz VGA timing from CLOCK_50 using a divide-by-2 pixel enable. It issues framebuffer read coordinates and consumes the 1-cycle-latency read data. It expands the 8-bit RGB332 pixel to the 8-bit-per-channel VGA DAC outputs with aligned sync and blank. It also provides frame_start and in_vblank so writers can update the framebuffer outside active video.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_timing.sv | 76 +++++++
 rtl/vga_scanout.sv | 111 +++++++++++
 tb/tb_vga_scanout.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, bus types and RGB332 colour expansion.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned COORD_W   = 11;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned CHAN_W    = 8;

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  // Bit replication keeps full-scale codes at 0x00/0xFF.
  function automatic rgb_t rgb332_expand(input logic [PIX_W-1:0] p);
    rgb_t c;
    c.r = {p[7:5], p[7:5], p[7:6]};
    c.g = {p[4:2], p[4:2], p[4:3]};
    c.b = {p[1:0], p[1:0], p[1:0], p[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v scan counters and sync/blank/vblank decode.
module vga_timing import vga_pkg::*; #(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK,
  parameter int unsigned COORD_W   = vga_pkg::COORD_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_phase,
  output logic [COORD_W-1:0] o_h_next_c,
  output logic [COORD_W-1:0] o_v_next_c,
  output logic               o_next_vis_c,
  output logic               o_frame_edge_c,
  output logic               o_hs_n_c,
  output logic               o_vs_n_c,
  output logic               o_blank_n_c,
  output logic               o_vblank
);

  localparam int unsigned H_TOT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEG = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  logic               r_phase;
  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic               r_vblank;
  logic [COORD_W-1:0] w_h_next;
  logic [COORD_W-1:0] w_v_next;

  // Coordinates the counters move to on the next tick.
  always_comb begin
    w_h_next = r_h + COORD_W'(1);
    w_v_next = r_v;
    if (r_h == COORD_W'(H_TOT - 1)) begin
      w_h_next = '0;
      w_v_next = (r_v == COORD_W'(V_TOT - 1)) ? '0 : r_v + COORD_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase  <= 1'b0;
      r_h      <= '0;
      r_v      <= '0;
      r_vblank <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      if (r_phase) begin
        r_h      <= w_h_next;
        r_v      <= w_v_next;
        r_vblank <= (w_v_next >= COORD_W'(V_VISIBLE));
      end
    end
  end

  assign o_phase        = r_phase;
  assign o_vblank       = r_vblank;
  assign o_h_next_c     = w_h_next;
  assign o_v_next_c     = w_v_next;
  assign o_next_vis_c   = (w_h_next < COORD_W'(H_VISIBLE)) && (w_v_next < COORD_W'(V_VISIBLE));
  assign o_frame_edge_c = r_phase && (w_h_next == '0) && (w_v_next == COORD_W'(V_VISIBLE));
  assign o_hs_n_c       = !((r_h >= COORD_W'(HS_BEG)) && (r_h < COORD_W'(HS_END)));
  assign o_vs_n_c       = !((r_v >= COORD_W'(VS_BEG)) && (r_v < COORD_W'(VS_END)));
  assign o_blank_n_c    = (r_h < COORD_W'(H_VISIBLE)) && (r_v < COORD_W'(V_VISIBLE));

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: read-address generation, RGB332 expansion and DAC output stage.
module vga_scanout import vga_pkg::*; #(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK,
  parameter int unsigned COORD_W   = vga_pkg::COORD_W
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pixel_in,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [CHAN_W-1:0]  VGA_R,
  output logic [CHAN_W-1:0]  VGA_G,
  output logic [CHAN_W-1:0]  VGA_B,
  output logic               frame_start,
  output logic               in_vblank
);

  logic               w_phase;
  logic [COORD_W-1:0] w_h_next;
  logic [COORD_W-1:0] w_v_next;
  logic               w_next_vis;
  logic               w_frame_edge;
  logic               w_hs_n;
  logic               w_vs_n;
  logic               w_blank_n;
  logic               w_vblank;
  rgb_t               w_rgb;

  logic [COORD_W-1:0] r_rd_x;
  logic [COORD_W-1:0] r_rd_y;
  logic               r_hs;
  logic               r_vs;
  logic               r_blank_n;
  logic               r_frame_start;
  rgb_t               r_rgb;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .COORD_W   (COORD_W)
  ) u_timing (
    .i_clk          (CLOCK_50),
    .i_rst          (reset),
    .o_phase        (w_phase),
    .o_h_next_c     (w_h_next),
    .o_v_next_c     (w_v_next),
    .o_next_vis_c   (w_next_vis),
    .o_frame_edge_c (w_frame_edge),
    .o_hs_n_c       (w_hs_n),
    .o_vs_n_c       (w_vs_n),
    .o_blank_n_c    (w_blank_n),
    .o_vblank       (w_vblank)
  );

  assign w_rgb = w_blank_n ? rgb332_expand(pixel_in) : '0;

  // Address tracks the counters; the DAC stage closes each pixel one tick later with the returned data.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_rd_x        <= '0;
      r_rd_y        <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_edge;
      if (w_phase) begin
        r_rd_x    <= w_next_vis ? w_h_next : '0;
        r_rd_y    <= w_next_vis ? w_v_next : '0;
        r_hs      <= w_hs_n;
        r_vs      <= w_vs_n;
        r_blank_n <= w_blank_n;
        r_rgb     <= w_rgb;
      end
    end
  end

  assign rd_x        = r_rd_x;
  assign rd_y        = r_rd_y;
  assign VGA_CLK     = w_phase;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = r_rgb.r;
  assign VGA_G       = r_rgb.g;
  assign VGA_B       = r_rgb.b;
  assign frame_start = r_frame_start;
  assign in_vblank   = w_vblank;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench: full-size scanout for line timing/colour, shrunken timing for frame-level behaviour.
`timescale 1ns/1ps
module tb_vga_scanout;

  typedef struct packed {
    logic [10:0] rx;
    logic [10:0] ry;
    logic        clk;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sn;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        fs;
    logic        vb;
  } obs_t;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
  } cfg_t;

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  localparam cfg_t CFG_A = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33};
  localparam cfg_t CFG_B = '{hv:16, hf:2, hs:3, hb:4, vv:6, vf:2, vs:2, vb:3};
  localparam obs_t RESET_OBS = '{rx:11'd0, ry:11'd0, clk:1'b0, hs:1'b1, vs:1'b1, bn:1'b0,
                                 sn:1'b1, r:8'd0, g:8'd0, b:8'd0, fs:1'b0, vb:1'b0};

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [7:0]  pix_a, pix_b;
  logic [10:0] rd_x_a, rd_y_a, rd_x_b, rd_y_b;
  logic        vclk_a, hs_a, vs_a, bn_a, sn_a, fs_a, vb_a;
  logic        vclk_b, hs_b, vs_b, bn_b, sn_b, fs_b, vb_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  obs_t        obs_a, obs_b;

  int          ka, kb;
  int          checks, failures;
  logic [7:0]  pat [256];
  vec_t        tbl [8];
  int          hs_falls[$], vs_falls[$], fs_ks[$];
  int          hs_low_w, vs_low_w, max_x, fs_high, vb_high, n, rst_pt;
  logic        prev_hs, prev_vs, prev_fs;

  always #10 clk = ~clk;

  vga_scanout u_dut_a (
    .CLOCK_50(clk), .reset(rst_a), .pixel_in(pix_a), .rd_x(rd_x_a), .rd_y(rd_y_a),
    .VGA_CLK(vclk_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .frame_start(fs_a), .in_vblank(vb_a)
  );

  vga_scanout #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .COORD_W(11)
  ) u_dut_b (
    .CLOCK_50(clk), .reset(rst_b), .pixel_in(pix_b), .rd_x(rd_x_b), .rd_y(rd_y_b),
    .VGA_CLK(vclk_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .frame_start(fs_b), .in_vblank(vb_b)
  );

  assign obs_a = {rd_x_a, rd_y_a, vclk_a, hs_a, vs_a, bn_a, sn_a, r_a, g_a, b_a, fs_a, vb_a};
  assign obs_b = {rd_x_b, rd_y_b, vclk_b, hs_b, vs_b, bn_b, sn_b, r_b, g_b, b_b, fs_b, vb_b};

  // CLOCK_50 edges since reset release, per DUT.
  always @(posedge clk or posedge rst_a) if (rst_a) ka <= 0; else ka <= ka + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) kb <= 0; else kb <= kb + 1;

  function automatic logic [7:0] fb(input logic [10:0] x, input logic [10:0] y);
    return pat[8'((int'(x) + 7 * int'(y)) % 256)];
  endfunction

  // Framebuffer with one clock of read latency; (0,0) holds 0xFF so blanking always sees non-zero data.
  always @(posedge clk) begin
    pix_a <= fb(rd_x_a, rd_y_a);
    pix_b <= fb(rd_x_b, rd_y_b);
  end

  function automatic logic [7:0] lvl(input int v, input int maxv);
    return 8'((v * 255 + maxv / 2) / maxv);
  endfunction

  // Expected outputs after k edges: counters sit on pixel k/2, DAC shows the pixel before it.
  function automatic obs_t model(input int k, input cfg_t c);
    obs_t e;
    int ht, vt, p, h, v, q, hq, vq;
    logic [7:0] px;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    p = k / 2;
    h = p % ht;
    v = (p / ht) % vt;
    e = '0;
    e.sn = 1'b1;
    e.clk = (k % 2 == 1);
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (h < c.hv && v < c.vv) begin
      e.rx = 11'(h);
      e.ry = 11'(v);
    end
    e.vb = (v >= c.vv);
    e.fs = (k > 0) && (k % 2 == 0) && (h == 0) && (v == c.vv);
    if (p > 0) begin
      q  = p - 1;
      hq = q % ht;
      vq = (q / ht) % vt;
      e.hs = !(hq >= c.hv + c.hf && hq < c.hv + c.hf + c.hs);
      e.vs = !(vq >= c.vv + c.vf && vq < c.vv + c.vf + c.vs);
      if (hq < c.hv && vq < c.vv) begin
        e.bn = 1'b1;
        px = pat[8'((hq + 7 * vq) % 256)];
        e.r = lvl(int'(px[7:5]), 7);
        e.g = lvl(int'(px[4:2]), 7);
        e.b = lvl(int'(px[1:0]), 3);
      end
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t ka=%0d kb=%0d actual=%h required=%h", nm, $time, ka, kb, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic wait_k(input bit sel, input int t);
    int cnt;
    cnt = 0;
    while (((sel ? kb : ka) < t) && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    if ((sel ? kb : ka) < t) begin
      checks++;
      failures++;
      $display("FAIL wait_k target=%0d reached=%0d", t, sel ? kb : ka);
    end
  endtask

  always @(negedge clk) begin
    cmp("stream_a", obs_a, model(ka, CFG_A));
    cmp("stream_b", obs_b, model(kb, CFG_B));
  end

  initial begin
    #5ms;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) pat[i] = 8'($urandom);
    pat[0] = 8'hFF;
    tbl[0] = '{pix:8'hE0, r:8'hFF, g:8'h00, b:8'h00};
    tbl[1] = '{pix:8'h1C, r:8'h00, g:8'hFF, b:8'h00};
    tbl[2] = '{pix:8'h03, r:8'h00, g:8'h00, b:8'hFF};
    tbl[3] = '{pix:8'h92, r:8'h92, g:8'h92, b:8'hAA};
    tbl[4] = '{pix:8'hFF, r:8'hFF, g:8'hFF, b:8'hFF};
    tbl[5] = '{pix:8'h00, r:8'h00, g:8'h00, b:8'h00};
    tbl[6] = '{pix:8'h49, r:8'h49, g:8'h49, b:8'h55};
    tbl[7] = '{pix:8'h6D, r:8'h6D, g:8'h6D, b:8'h55};
    for (int i = 0; i < 8; i++) pat[i + 1] = tbl[i].pix;

    repeat (3) @(negedge clk);
    cmp("reset_a", obs_a, RESET_OBS);
    #2 rst_a = 1'b0;

    // Colour table along row 0: address at k=2x, DAC output two clocks later.
    for (int i = 0; i < 8; i++) begin
      wait_k(1'b0, 2 * (i + 1));
      chk("tbl_rd_x", int'(rd_x_a), i + 1);
      wait_k(1'b0, 2 * (i + 1) + 2);
      chk("tbl_r", int'(r_a), int'(tbl[i].r));
      chk("tbl_g", int'(g_a), int'(tbl[i].g));
      chk("tbl_b", int'(b_a), int'(tbl[i].b));
    end

    // Asynchronous reset mid-line at h=300.
    wait_k(1'b0, 601);
    #2 rst_a = 1'b1;
    #1 cmp("async_reset_a", obs_a, RESET_OBS);
    @(negedge clk);
    #2 rst_a = 1'b0;
    #1 chk("rel_rd_x0", int'(rd_x_a), 0);
    wait_k(1'b0, 1);
    chk("rel_rd_x1", int'(rd_x_a), 0);
    wait_k(1'b0, 2);
    chk("rel_rd_x2", int'(rd_x_a), 1);
    chk("rel_rd_y2", int'(rd_y_a), 0);

    // Line timing and address range over two lines.
    prev_hs = 1'b1;
    hs_low_w = -1;
    max_x = 0;
    n = 0;
    while (ka < 3700 && n < 5000) begin
      @(negedge clk);
      n++;
      if (prev_hs && !hs_a) hs_falls.push_back(ka);
      if (!prev_hs && hs_a && hs_falls.size() == 1) hs_low_w = ka - hs_falls[0];
      prev_hs = hs_a;
      if (int'(rd_x_a) > max_x) max_x = int'(rd_x_a);
    end
    chk("hs_fall_count", hs_falls.size(), 2);
    if (hs_falls.size() >= 2) begin
      chk("hs_first_fall", hs_falls[0], 1314);
      chk("hs_period", hs_falls[1] - hs_falls[0], 1600);
    end
    chk("hs_low_width", hs_low_w, 192);
    chk("rd_x_max", max_x, 639);

    // Frame-level behaviour on the shrunken timing (25x13 pixels, 650 clocks/frame).
    #2 rst_b = 1'b0;
    rst_pt = $urandom_range(100, 500);
    wait_k(1'b1, rst_pt);
    #2 rst_b = 1'b1;
    #1 cmp("async_reset_b", obs_b, RESET_OBS);
    @(negedge clk);
    #2 rst_b = 1'b0;
    prev_vs = 1'b1;
    prev_fs = 1'b0;
    vs_low_w = -1;
    fs_high = 0;
    vb_high = 0;
    n = 0;
    while (kb < 1950 && n < 4000) begin
      @(negedge clk);
      n++;
      if (fs_b) fs_high++;
      if (!prev_fs && fs_b) fs_ks.push_back(kb);
      if (prev_vs && !vs_b) vs_falls.push_back(kb);
      if (!prev_vs && vs_b && vs_falls.size() == 1) vs_low_w = kb - vs_falls[0];
      if (kb >= 651 && kb <= 1300 && vb_b) vb_high++;
      prev_fs = fs_b;
      prev_vs = vs_b;
    end
    chk("fs_pulses", fs_ks.size(), 3);
    chk("fs_high_cycles", fs_high, 3);
    if (fs_ks.size() >= 2) begin
      chk("fs_first", fs_ks[0], 300);
      chk("fs_period", fs_ks[1] - fs_ks[0], 650);
    end
    chk("vs_fall_count", vs_falls.size(), 3);
    if (vs_falls.size() >= 2) chk("vs_period", vs_falls[1] - vs_falls[0], 650);
    chk("vs_low_width", vs_low_w, 100);
    chk("vblank_cycles", vb_high, 350);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
